dps_uart_rx_engine: RTL and testbench

Bit-level UART receive engine for the DPS serial channel. It synchronises the raw `iUART_RXD` pin, detects and validates start bits, and samples 8N1 frames at mid-bit using a per-bit clock count supplied by the baudrate selector. It delivers each byte as a one-cycle pulse to the RX FIFO write side. It also reports framing errors and overruns (byte arrives while the FIFO is full) for the SCI status/IRQ logic.

---
 rtl/dps_uart_rx_engine.sv | 134 +++++++++++++
 tb/tb_dps_uart_rx_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dps_uart_rx_engine.sv
// UART 8N1 receive engine: pin synchroniser, start-bit validation and mid-bit sampling.
// Delivers one result pulse per frame: good byte, overrun or framing error.
module dps_uart_rx_engine #(
  parameter int unsigned P_COUNT_WIDTH = 20
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET,
  input  logic                     iENABLE,
  input  logic [P_COUNT_WIDTH-1:0] iBAUD_COUNT,
  input  logic                     iUART_RXD,
  input  logic                     iFIFO_FULL,
  output logic                     oRX_VALID,
  output logic [7:0]               oRX_DATA,
  output logic                     oRX_FRAME_ERR,
  output logic                     oRX_OVERRUN,
  output logic                     oRX_BUSY
);

  localparam int unsigned CW = P_COUNT_WIDTH;
  localparam logic [CW-1:0] MIN_BIT_PERIOD = CW'(4);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [1:0]    rxdSync;
  logic          rxdS;
  logic          rxdD;
  logic [CW-1:0] bitCount;
  logic [CW-1:0] bitPeriod;
  logic [2:0]    bitIndex;
  logic [7:0]    shiftReg;
  logic [CW-1:0] baudEff;
  logic [CW-1:0] halfLast;
  logic [CW-1:0] periodLast;
  logic          startEdge;

  assign rxdS       = rxdSync[1];
  assign baudEff    = (iBAUD_COUNT < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : iBAUD_COUNT;
  assign halfLast   = (bitPeriod >> 1) - CW'(1);
  assign periodLast = bitPeriod - CW'(1);
  assign startEdge  = !rxdS && rxdD;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      rxdSync <= 2'b11;
      rxdD    <= 1'b1;
    end else begin
      rxdSync <= {rxdSync[0], iUART_RXD};
      rxdD    <= rxdS;
    end
  end

  // Frame FSM with registered result pulses and busy flag.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state         <= IDLE;
      bitCount      <= '0;
      bitPeriod     <= MIN_BIT_PERIOD;
      bitIndex      <= 3'd0;
      shiftReg      <= 8'h00;
      oRX_VALID     <= 1'b0;
      oRX_DATA      <= 8'h00;
      oRX_FRAME_ERR <= 1'b0;
      oRX_OVERRUN   <= 1'b0;
      oRX_BUSY      <= 1'b0;
    end else begin
      oRX_VALID     <= 1'b0;
      oRX_FRAME_ERR <= 1'b0;
      oRX_OVERRUN   <= 1'b0;
      if (!iENABLE) begin
        state    <= IDLE;
        oRX_BUSY <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (startEdge) begin
              state     <= START;
              oRX_BUSY  <= 1'b1;
              bitCount  <= '0;
              bitIndex  <= 3'd0;
              bitPeriod <= baudEff;
            end
          end
          START: begin
            if (bitCount == halfLast) begin
              bitCount <= '0;
              if (rxdS) begin
                state    <= IDLE;
                oRX_BUSY <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              bitCount <= bitCount + CW'(1);
            end
          end
          DATA: begin
            if (bitCount == periodLast) begin
              bitCount <= '0;
              shiftReg <= {rxdS, shiftReg[7:1]};
              bitIndex <= bitIndex + 3'd1;
              if (bitIndex == 3'd7) state <= STOP;
            end else begin
              bitCount <= bitCount + CW'(1);
            end
          end
          STOP: begin
            if (bitCount == periodLast) begin
              state    <= IDLE;
              oRX_BUSY <= 1'b0;
              bitCount <= '0;
              if (!rxdS) begin
                oRX_FRAME_ERR <= 1'b1;
              end else if (iFIFO_FULL) begin
                oRX_OVERRUN <= 1'b1;
              end else begin
                oRX_VALID <= 1'b1;
                oRX_DATA  <= shiftReg;
              end
            end else begin
              bitCount <= bitCount + CW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            oRX_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dps_uart_rx_engine.sv
// Scoreboard bench for dps_uart_rx_engine: frames are described at byte level,
// expected result/cycle/data are queued, and a monitor checks every result pulse.
module tb_dps_uart_rx_engine;

  localparam int unsigned CW = 20;

  logic          iCLOCK = 1'b0;
  logic          iRESET;
  logic          iENABLE;
  logic [CW-1:0] iBAUD_COUNT;
  logic          iUART_RXD;
  logic          iFIFO_FULL;
  logic          oRX_VALID;
  logic [7:0]    oRX_DATA;
  logic          oRX_FRAME_ERR;
  logic          oRX_OVERRUN;
  logic          oRX_BUSY;

  dps_uart_rx_engine #(.P_COUNT_WIDTH(CW)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iENABLE(iENABLE), .iBAUD_COUNT(iBAUD_COUNT),
    .iUART_RXD(iUART_RXD), .iFIFO_FULL(iFIFO_FULL), .oRX_VALID(oRX_VALID),
    .oRX_DATA(oRX_DATA), .oRX_FRAME_ERR(oRX_FRAME_ERR), .oRX_OVERRUN(oRX_OVERRUN),
    .oRX_BUSY(oRX_BUSY)
  );

  always #5 iCLOCK = ~iCLOCK;

  // kind bits: {valid, overrun, frameErr}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cycle;
  } expect_t;

  expect_t sbQ[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  logic [7:0] modelData = 8'h00;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge iCLOCK) begin
    if (!iRESET && (oRX_VALID || oRX_OVERRUN || oRX_FRAME_ERR)) begin
      if (sbQ.size() == 0) begin
        check("unexpected_pulse", int'({oRX_VALID, oRX_OVERRUN, oRX_FRAME_ERR}), 0);
      end else begin
        expect_t e;
        e = sbQ.pop_front();
        check("pulse_kind", int'({oRX_VALID, oRX_OVERRUN, oRX_FRAME_ERR}), int'(e.kind));
        check("pulse_cycle", cyc, e.cycle);
        check("rx_data", int'(oRX_DATA), int'(e.data));
        check("busy_at_pulse", int'(oRX_BUSY), 0);
      end
    end
  end

  task automatic holdLine(input logic v, input int n);
    iUART_RXD = v;
    repeat (n) begin
      @(posedge iCLOCK);
      #1;
    end
  endtask

  // Send one 8N1 frame; abortBit >= 0 drops iENABLE at that data bit and expects nothing.
  task automatic sendFrame(input logic [7:0] b, input int rawBaud, input int midBaud,
                           input logic stopBit, input logic full, input int gap,
                           input int abortBit);
    int len;
    int p;
    expect_t e;
    len = (rawBaud < 4) ? 4 : rawBaud;
    iBAUD_COUNT = CW'(rawBaud);
    iFIFO_FULL = full;
    p = cyc;
    if (abortBit < 0) begin
      if (!stopBit) e.kind = 3'b001;
      else if (full) e.kind = 3'b010;
      else begin
        e.kind = 3'b100;
        modelData = b;
      end
      e.data = modelData;
      // Start edge seen two edges after the pin falls; pulse follows the stop sample.
      e.cycle = p + 3 + len / 2 + 9 * len;
      sbQ.push_back(e);
    end
    holdLine(1'b0, len);
    iBAUD_COUNT = CW'(midBaud);
    for (int k = 0; k < 8; k++) begin
      if (k == abortBit) begin
        iENABLE = 1'b0;
        holdLine(1'b1, 2);
        check("busy_after_disable", int'(oRX_BUSY), 0);
        iENABLE = 1'b1;
        holdLine(1'b1, 12 * len);
        return;
      end
      holdLine(b[k], len);
    end
    holdLine(stopBit, len);
    if (gap > 0) holdLine(1'b1, gap);
  endtask

  initial begin
    int p;
    iRESET = 1'b1;
    iENABLE = 1'b1;
    iBAUD_COUNT = CW'(8);
    iUART_RXD = 1'b1;
    iFIFO_FULL = 1'b0;
    #1;
    check("reset_valid", int'(oRX_VALID), 0);
    check("reset_data", int'(oRX_DATA), 0);
    check("reset_ferr", int'(oRX_FRAME_ERR), 0);
    check("reset_ovr", int'(oRX_OVERRUN), 0);
    check("reset_busy", int'(oRX_BUSY), 0);
    repeat (3) @(posedge iCLOCK);
    #1;
    iRESET = 1'b0;
    holdLine(1'b1, 20);

    // Good frame at N=8
    sendFrame(8'hA5, 8, 8, 1'b1, 1'b0, 5, -1);
    holdLine(1'b1, 10);

    // Reset mid-frame with the line toggling
    iBAUD_COUNT = CW'(8);
    holdLine(1'b0, 8);
    holdLine(1'b1, 8);
    holdLine(1'b0, 5);
    check("busy_before_reset", int'(oRX_BUSY), 1);
    #2;
    iRESET = 1'b1;
    #1;
    check("async_reset_busy", int'(oRX_BUSY), 0);
    check("async_reset_data", int'(oRX_DATA), 0);
    check("async_reset_pulses", int'({oRX_VALID, oRX_OVERRUN, oRX_FRAME_ERR}), 0);
    modelData = 8'h00;
    holdLine(1'b1, 2);
    iRESET = 1'b0;
    holdLine(1'b1, 100);
    check("idle_busy", int'(oRX_BUSY), 0);

    // Glitch rejection at N=16
    iBAUD_COUNT = CW'(16);
    p = cyc;
    holdLine(1'b0, 3);
    check("glitch_busy_high", int'(oRX_BUSY), 1);
    holdLine(1'b1, 10);
    check("glitch_busy_low", cyc - p, 13);
    check("glitch_returns_idle", int'(oRX_BUSY), 0);
    holdLine(1'b1, 200);

    // Framing error, then a good frame after the line returns high
    sendFrame(8'h3C, 8, 8, 1'b0, 1'b0, 3, -1);
    sendFrame(8'h81, 8, 8, 1'b1, 1'b0, 5, -1);

    // Overrun
    sendFrame(8'h5A, 8, 8, 1'b1, 1'b1, 5, -1);

    // Minimum N, back-to-back frames, baud changed mid-frame
    sendFrame(8'h00, 2, 13, 1'b1, 1'b0, 0, -1);
    sendFrame(8'hFF, 2, 9, 1'b1, 1'b0, 5, -1);

    // Enable drop mid-frame discards the frame
    sendFrame(8'hC3, 8, 8, 1'b1, 1'b0, 0, 3);
    sendFrame(8'h6E, 5, 5, 1'b1, 1'b0, 5, -1);

    // Randomised frames
    for (int i = 0; i < 25; i++) begin
      sendFrame(8'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 15)), logic'($urandom_range(0, 5) != 0),
                logic'($urandom_range(0, 3) == 0), int'($urandom_range(1, 5)), -1);
    end

    holdLine(1'b1, 60);
    check("scoreboard_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
